// File: rtl/dmem_lsu_port_pkg.sv
// rtl/dmem_lsu_port_pkg.sv - shared encodings and lane-mask helpers for the data-memory load/store port
package dmem_lsu_port_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_WAIT = 2'b01,
    RESP    = 2'b10
  } state_e;

  // Lanes touched by an access of the given size at byte offset off.
  function automatic logic [LANES-1:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
    logic [LANES-1:0] m;
    case (size)
      SZ_B:    m = 4'b0001 << off;
      SZ_H:    m = 4'b0011 << {off[1], 1'b0};
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Size/offset combinations that cannot be served by one word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lsu_port_if.sv
// rtl/dmem_lsu_port_if.sv - request/response and byte-lane memory signals of the load/store port
interface dmem_lsu_port_if #(
  parameter int ADDR_WIDTH = 13
);

  logic                  REQ_VALID;
  logic                  REQ_READY;
  logic                  REQ_WE;
  logic [1:0]            REQ_SIZE;
  logic                  REQ_UNSIGNED;
  logic [ADDR_WIDTH-1:0] REQ_ADDR;
  logic [31:0]           REQ_WDATA;
  logic                  RSP_VALID;
  logic                  RSP_READY;
  logic [31:0]           RSP_RDATA;
  logic                  RSP_ERR;
  logic [ADDR_WIDTH-1:0] MEM_W_ADDR;
  logic [ADDR_WIDTH-1:0] MEM_R_ADDR;
  logic [3:0]            MEM_WE;
  logic [3:0]            MEM_RE;
  logic [31:0]           MEM_DIN;
  logic [31:0]           MEM_DOUT;

  // Core plus lane side: issues requests, consumes responses, serves lane reads.
  modport master (
    output REQ_VALID, REQ_WE, REQ_SIZE, REQ_UNSIGNED, REQ_ADDR, REQ_WDATA, RSP_READY, MEM_DOUT,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
    input  MEM_W_ADDR, MEM_R_ADDR, MEM_WE, MEM_RE, MEM_DIN
  );

  // The load/store port itself.
  modport slave (
    input  REQ_VALID, REQ_WE, REQ_SIZE, REQ_UNSIGNED, REQ_ADDR, REQ_WDATA, RSP_READY, MEM_DOUT,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
    output MEM_W_ADDR, MEM_R_ADDR, MEM_WE, MEM_RE, MEM_DIN
  );

endinterface

// File: rtl/dmem_lsu_port_lane_align.sv
// rtl/dmem_lsu_port_lane_align.sv - store data placement onto lanes and load data extraction/extension
module dmem_lane_align
  import dmem_lsu_port_pkg::*;
(
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [31:0] st_lane_data,
  input  logic [1:0]  ld_off,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_lane_data,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  // Store: move right-justified data up to its byte lane; load: bring it back down and extend.
  always_comb begin
    st_lane_data = st_data << {st_off, 3'b000};
    ld_shifted   = ld_lane_data >> {ld_off, 3'b000};
    case (ld_size)
      SZ_B:    ld_data = {{24{~ld_unsigned & ld_shifted[7]}}, ld_shifted[7:0]};
      SZ_H:    ld_data = {{16{~ld_unsigned & ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_data = ld_shifted;
    endcase
  end

endmodule

// File: rtl/dmem_lsu_port.sv
// rtl/dmem_lsu_port.sv - load/store port driving four byte-wide data lanes; DMEM_MISALIGN_ERR_EN enables error responses
module dmem_lsu_port
  import dmem_lsu_port_pkg::*;
#(
  parameter int ADDR_WIDTH = 13
) (
  input  logic            CLK,
  input  logic            RST_N,
  dmem_lsu_port_if.slave  bus
);

  state_e                state;
  logic [1:0]            ld_off;
  logic [1:0]            ld_size;
  logic                  ld_unsigned;
  logic [1:0]            eff_size;
  logic [1:0]            eff_off;
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic                  misalign;
  logic [3:0]            mask;
  logic [31:0]           st_lane_data;
  logic [31:0]           ld_data;

  // Resolve the access size/offset actually used for the lanes.
  always_comb begin
    eff_size = bus.REQ_SIZE;
    eff_off  = bus.REQ_ADDR[1:0];
    eff_addr = bus.REQ_ADDR;
`ifdef DMEM_MISALIGN_ERR_EN
    misalign = is_misaligned(bus.REQ_SIZE, bus.REQ_ADDR[1:0]);
`else
    misalign = 1'b0;
    if (eff_size == SZ_RSV) eff_size = SZ_W;
    if (eff_size == SZ_H) eff_off[0] = 1'b0;
    if (eff_size == SZ_W) eff_off = 2'b00;
    eff_addr[1:0] = eff_off;
`endif
    mask = byte_mask(eff_size, eff_off);
  end

  dmem_lane_align u_align (
    .st_off       (eff_off),
    .st_data      (bus.REQ_WDATA),
    .st_lane_data (st_lane_data),
    .ld_off       (ld_off),
    .ld_size      (ld_size),
    .ld_unsigned  (ld_unsigned),
    .ld_lane_data (bus.MEM_DOUT),
    .ld_data      (ld_data)
  );

  // Request/response FSM; every output is registered here.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state          <= IDLE;
      bus.REQ_READY  <= 1'b0;
      bus.RSP_VALID  <= 1'b0;
      bus.RSP_RDATA  <= '0;
      bus.RSP_ERR    <= 1'b0;
      bus.MEM_WE     <= '0;
      bus.MEM_RE     <= '0;
      bus.MEM_DIN    <= '0;
      bus.MEM_W_ADDR <= '0;
      bus.MEM_R_ADDR <= '0;
      ld_off         <= '0;
      ld_size        <= '0;
      ld_unsigned    <= 1'b0;
    end else begin
      bus.MEM_WE <= '0;
      bus.MEM_RE <= '0;
      case (state)
        IDLE: begin
          bus.REQ_READY <= 1'b1;
          if (bus.REQ_VALID && bus.REQ_READY) begin
            if (misalign) begin
              bus.RSP_VALID <= 1'b1;
              bus.RSP_ERR   <= 1'b1;
              bus.RSP_RDATA <= '0;
              bus.REQ_READY <= 1'b0;
              state         <= RESP;
            end else if (bus.REQ_WE) begin
              bus.MEM_W_ADDR <= eff_addr;
              bus.MEM_DIN    <= st_lane_data;
              bus.MEM_WE     <= mask;
            end else begin
              bus.MEM_R_ADDR <= eff_addr;
              bus.MEM_RE     <= mask;
              ld_off         <= eff_off;
              ld_size        <= eff_size;
              ld_unsigned    <= bus.REQ_UNSIGNED;
              bus.REQ_READY  <= 1'b0;
              state          <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          bus.REQ_READY <= 1'b0;
          bus.RSP_RDATA <= ld_data;
          bus.RSP_ERR   <= 1'b0;
          bus.RSP_VALID <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          bus.REQ_READY <= 1'b0;
          if (bus.RSP_READY) begin
            bus.RSP_VALID <= 1'b0;
            bus.RSP_ERR   <= 1'b0;
            bus.REQ_READY <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          bus.REQ_READY <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu_port.sv
// tb/tb_dmem_lsu_port.sv - directed bench for the data-memory load/store port with a four-lane memory model
module tb_dmem_lsu_port;
  import dmem_lsu_port_pkg::*;

  localparam int AW = 13;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 CLK = ~CLK;

  dmem_lsu_port_if #(.ADDR_WIDTH(AW)) bus ();

  dmem_lsu_port #(.ADDR_WIDTH(AW)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  logic [7:0] lane_mem [0:3][0:(2**(AW-2))-1];

  // Byte lanes: write and read on the falling edge.
  always @(negedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.MEM_WE[i]) lane_mem[i][bus.MEM_W_ADDR[AW-1:2]] <= bus.MEM_DIN[8*i +: 8];
      if (bus.MEM_RE[i]) bus.MEM_DOUT[8*i +: 8] <= lane_mem[i][bus.MEM_R_ADDR[AW-1:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!bus.REQ_READY && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk({tag, "_req_ready"}, {31'b0, bus.REQ_READY}, 32'd1);
  endtask

  task automatic do_store(input string tag, input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [1:0] sz, input logic [3:0] exp_we, input logic [31:0] exp_din);
    wait_ready(tag);
    bus.REQ_VALID = 1'b1;
    bus.REQ_WE = 1'b1;
    bus.REQ_SIZE = sz;
    bus.REQ_ADDR = a;
    bus.REQ_WDATA = d;
    bus.REQ_UNSIGNED = 1'b0;
    @(posedge CLK);
    #1 bus.REQ_VALID = 1'b0;
    @(negedge CLK);
    chk({tag, "_we"}, {28'b0, bus.MEM_WE}, {28'b0, exp_we});
    chk({tag, "_din"}, bus.MEM_DIN, exp_din);
    chk({tag, "_waddr"}, {19'b0, bus.MEM_W_ADDR}, {19'b0, a});
  endtask

  task automatic do_load(input string tag, input logic [AW-1:0] a, input logic [1:0] sz,
                         input logic uns, input int hold,
                         output logic [31:0] rd, output logic err, output int lat,
                         output logic [3:0] re_seen, output logic [AW-1:0] raddr_seen);
    wait_ready(tag);
    bus.REQ_VALID = 1'b1;
    bus.REQ_WE = 1'b0;
    bus.REQ_SIZE = sz;
    bus.REQ_ADDR = a;
    bus.REQ_WDATA = 32'h0;
    bus.REQ_UNSIGNED = uns;
    @(posedge CLK);
    #1 bus.REQ_VALID = 1'b0;
    re_seen = bus.MEM_RE;
    raddr_seen = bus.MEM_R_ADDR;
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!bus.RSP_VALID && lat < 20);
    rd = bus.RSP_RDATA;
    err = bus.RSP_ERR;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      chk({tag, "_hold_valid"}, {31'b0, bus.RSP_VALID}, 32'd1);
      chk({tag, "_hold_rdata"}, bus.RSP_RDATA, rd);
      chk({tag, "_hold_req_ready"}, {31'b0, bus.REQ_READY}, 32'd0);
    end
    bus.RSP_READY = 1'b1;
    @(posedge CLK);
    #1 bus.RSP_READY = 1'b0;
    @(negedge CLK);
    chk({tag, "_rsp_drop"}, {31'b0, bus.RSP_VALID}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]   rd;
    logic          err;
    int            lat;
    logic [3:0]    re;
    logic [AW-1:0] ra;

    bus.REQ_VALID = 1'b0;
    bus.REQ_WE = 1'b0;
    bus.REQ_SIZE = 2'b00;
    bus.REQ_UNSIGNED = 1'b0;
    bus.REQ_ADDR = '0;
    bus.REQ_WDATA = 32'h0;
    bus.RSP_READY = 1'b0;

    repeat (2) @(negedge CLK);
    chk("rst_req_ready", {31'b0, bus.REQ_READY}, 32'd0);
    chk("rst_rsp_valid", {31'b0, bus.RSP_VALID}, 32'd0);
    chk("rst_rsp_rdata", bus.RSP_RDATA, 32'h0);
    chk("rst_rsp_err", {31'b0, bus.RSP_ERR}, 32'd0);
    chk("rst_mem_we", {28'b0, bus.MEM_WE}, 32'd0);
    chk("rst_mem_re", {28'b0, bus.MEM_RE}, 32'd0);
    chk("rst_mem_din", bus.MEM_DIN, 32'h0);
    chk("rst_waddr", {19'b0, bus.MEM_W_ADDR}, 32'd0);
    chk("rst_raddr", {19'b0, bus.MEM_R_ADDR}, 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("post_rst_req_ready", {31'b0, bus.REQ_READY}, 32'd1);

    // word store then word load
    do_store("st_w10", 13'h0010, 32'hDEADBEEF, SZ_W, 4'b1111, 32'hDEADBEEF);
    do_load("ld_w10", 13'h0010, SZ_W, 1'b0, 0, rd, err, lat, re, ra);
    chk("ld_w10_re", {28'b0, re}, 32'h0000000F);
    chk("ld_w10_raddr", {19'b0, ra}, 32'h00000010);
    chk("ld_w10_rdata", rd, 32'hDEADBEEF);
    chk("ld_w10_lat", lat, 32'd2);
    chk("ld_w10_err", {31'b0, err}, 32'd0);

    // byte store at lane 3, signed and unsigned byte loads
    do_store("st_b13", 13'h0013, 32'h00000080, SZ_B, 4'b1000, 32'h80000000);
    do_load("ld_b13s", 13'h0013, SZ_B, 1'b0, 0, rd, err, lat, re, ra);
    chk("ld_b13s_re", {28'b0, re}, 32'h00000008);
    chk("ld_b13s_rdata", rd, 32'hFFFFFF80);
    do_load("ld_b13u", 13'h0013, SZ_B, 1'b1, 0, rd, err, lat, re, ra);
    chk("ld_b13u_rdata", rd, 32'h00000080);
    do_load("ld_w10b", 13'h0010, SZ_W, 1'b0, 0, rd, err, lat, re, ra);
    chk("ld_w10b_rdata", rd, 32'h80ADBEEF);

    // half loads from upper and lower halves
    do_store("st_w10c", 13'h0010, 32'h80017FFF, SZ_W, 4'b1111, 32'h80017FFF);
    do_load("ld_h12s", 13'h0012, SZ_H, 1'b0, 0, rd, err, lat, re, ra);
    chk("ld_h12s_re", {28'b0, re}, 32'h0000000C);
    chk("ld_h12s_rdata", rd, 32'hFFFF8001);
    do_load("ld_h10u", 13'h0010, SZ_H, 1'b1, 0, rd, err, lat, re, ra);
    chk("ld_h10u_rdata", rd, 32'h00007FFF);

    // response held while consumer stalls
    do_load("ld_stall", 13'h0010, SZ_W, 1'b0, 5, rd, err, lat, re, ra);
    chk("ld_stall_rdata", rd, 32'h80017FFF);

    // back-to-back stores, one per cycle
    wait_ready("b2b");
    for (int i = 0; i < 3; i++) begin
      bus.REQ_VALID = 1'b1;
      bus.REQ_WE = 1'b1;
      bus.REQ_SIZE = SZ_W;
      bus.REQ_ADDR = AW'(4 * i);
      bus.REQ_WDATA = 32'h11111111 * (i + 1);
      @(posedge CLK);
      @(negedge CLK);
      chk($sformatf("b2b%0d_we", i), {28'b0, bus.MEM_WE}, 32'h0000000F);
      chk($sformatf("b2b%0d_waddr", i), {19'b0, bus.MEM_W_ADDR}, 32'(4 * i));
      chk($sformatf("b2b%0d_ready", i), {31'b0, bus.REQ_READY}, 32'd1);
    end
    bus.REQ_VALID = 1'b0;
    @(negedge CLK);
    chk("b2b_we_drop", {28'b0, bus.MEM_WE}, 32'd0);
    do_load("ld_w4", 13'h0004, SZ_W, 1'b0, 0, rd, err, lat, re, ra);
    chk("ld_w4_rdata", rd, 32'h22222222);
    do_load("ld_w8", 13'h0008, SZ_W, 1'b0, 0, rd, err, lat, re, ra);
    chk("ld_w8_rdata", rd, 32'h33333333);

    // misaligned half load
    do_load("ld_h01", 13'h0001, SZ_H, 1'b0, 0, rd, err, lat, re, ra);
`ifdef DMEM_MISALIGN_ERR_EN
    chk("ld_h01_err", {31'b0, err}, 32'd1);
    chk("ld_h01_re", {28'b0, re}, 32'd0);
    chk("ld_h01_rdata", rd, 32'h0);
    chk("ld_h01_lat", lat, 32'd1);
`else
    chk("ld_h01_err", {31'b0, err}, 32'd0);
    chk("ld_h01_re", {28'b0, re}, 32'h00000003);
    chk("ld_h01_raddr", {19'b0, ra}, 32'd0);
    chk("ld_h01_rdata", rd, 32'h00001111);
`endif

    // reset while a response is pending
    wait_ready("rst_resp");
    bus.REQ_VALID = 1'b1;
    bus.REQ_WE = 1'b0;
    bus.REQ_SIZE = SZ_W;
    bus.REQ_ADDR = 13'h0010;
    @(posedge CLK);
    #1 bus.REQ_VALID = 1'b0;
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!bus.RSP_VALID && lat < 20);
    chk("rst_resp_valid_before", {31'b0, bus.RSP_VALID}, 32'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_resp_valid_cleared", {31'b0, bus.RSP_VALID}, 32'd0);
    chk("rst_resp_req_ready", {31'b0, bus.REQ_READY}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_resp_idle_ready", {31'b0, bus.REQ_READY}, 32'd1);
    chk("rst_resp_idle_valid", {31'b0, bus.RSP_VALID}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
